// File: rtl/ro_freq_counter.sv
// ro_freq_counter
// Ring-oscillator frequency counter. Gates the ring through ro_halt, lets it
// settle for a fixed number of clk cycles, then counts synchronized rising
// edges of ro_in over a programmable window of clk cycles. The result is
// reported with a single-cycle done pulse.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           asynchronous active-high reset
//   start         measurement request, honoured only in IDLE
//   window_cycles window length in clk cycles, latched on an accepted start
//   ro_in         ring oscillator output, asynchronous to clk
//   ro_halt       ring gating input: 1 stops the ring, 0 lets it run
//   busy          high through SETTLE and MEASURE
//   done          one-cycle pulse, count/overflow valid
//   count         rising edges counted in the last window (saturating)
//   overflow      sticky, set when an edge arrived with count already all-ones
module ro_freq_counter #(
    parameter int COUNT_W       = 32,
    parameter int WINDOW_W      = 24,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WINDOW_W-1:0] window_cycles,
    input  logic                ro_in,
    output logic                ro_halt,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  count,
    output logic                overflow
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    prev_r;
    logic                    ro_edge_s;
    logic [WINDOW_W-1:0]     win_q_r;
    logic [WINDOW_W-1:0]     win_cnt_r;
    logic [SETTLE_W-1:0]     settle_cnt_r;
    logic                    halt_nx_s;
    logic                    busy_nx_s;
    logic                    done_nx_s;

    // Synchronizer chain and edge-history flop, free-running in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], ro_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Rising edge of the synchronized ring output seen in this cycle.
    always_comb begin
        ro_edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; the settle and window counters count down to zero.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = SETTLE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_r != '0) begin
                    state_nx_s = SETTLE;
                end else if (win_q_r == '0) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = MEASURE;
                end
            end
            MEASURE: begin
                if (win_cnt_r == '0) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = MEASURE;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they describe.
    always_comb begin
        halt_nx_s = 1'b1;
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            SETTLE, MEASURE: begin
                halt_nx_s = 1'b0;
                busy_nx_s = 1'b1;
            end
            DONE:    done_nx_s = 1'b1;
            default: begin
                halt_nx_s = 1'b1;
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_halt <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            ro_halt <= halt_nx_s;
            busy    <= busy_nx_s;
            done    <= done_nx_s;
        end
    end

    // Window latch, settle/window down-counters and the saturating edge counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q_r      <= '0;
            win_cnt_r    <= '0;
            settle_cnt_r <= '0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        win_q_r      <= window_cycles;
                        settle_cnt_r <= SETTLE_W'(SETTLE_CYCLES - 1);
                        count        <= '0;
                        overflow     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r != '0) begin
                        settle_cnt_r <= settle_cnt_r - SETTLE_W'(1);
                    end else begin
                        // Unused when win_q_r is zero: SETTLE then goes straight to DONE.
                        win_cnt_r <= win_q_r - WINDOW_W'(1);
                    end
                end
                MEASURE: begin
                    win_cnt_r <= win_cnt_r - WINDOW_W'(1);
                    if (ro_edge_s) begin
                        // An edge that cannot be counted marks the result as saturated.
                        if (&count) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + COUNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ro_freq_counter.md
# ro_freq_counter

Measurement stage that consumes the ring-oscillator output of the gated NAND ring and converts it into a frequency count. It controls the ring's gating input, enables the ring for a programmable window of system-clock cycles, counts synchronized rising edges of the ring output, then halts the ring and reports the count with a done pulse. It sits between the ring oscillator macro and the register/readout logic of the reliability sensor IP.

## Interface
Parameters:
- COUNT_W, 32: width of edge counter and `count` output.
- WINDOW_W, 24: width of `window_cycles`.
- SYNC_STAGES, 2: flip-flops in the `ro_in` synchronizer, minimum 2.
- SETTLE_CYCLES, 4: cycles the ring runs before counting starts. Must be ≥ SYNC_STAGES+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a measurement; sampled only in IDLE.
- window_cycles  in  WINDOW_W  measurement window length in clk cycles; latched on accepted start.
- ro_in  in  1  ring oscillator output, asynchronous to clk.
- ro_halt  out  1  drives the ring gating input; 1 forces the NAND output high and stops oscillation, 0 lets the ring run.
- busy  out  1  high from the cycle after an accepted start up to and including the last MEASURE cycle.
- done  out  1  single-cycle pulse; count/overflow valid.
- count  out  COUNT_W  rising edges counted in the last window; holds until the next accepted start.
- overflow  out  1  sticky; counter saturated during the last window.

## Operation
- Synchronizer: `ro_in` passes through SYNC_STAGES flops, then one `prev` flop. Edge = sync_out & ~prev. Both update every cycle in all states.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE: ro_halt=1, busy=0. When start=1, latch window_cycles into win_q, clear count and overflow, load settle counter, go to SETTLE.
- SETTLE: ro_halt=0, busy=1. Edges are not counted. After SETTLE_CYCLES cycles go to MEASURE, or to DONE if win_q==0.
- MEASURE: ro_halt=0, busy=1. Each detected edge increments count. At all-ones, count saturates and overflow sets. Leave after exactly win_q cycles for DONE.
- DONE: ro_halt=1, busy=0, done=1 for one cycle. Then go to IDLE.
- start outside IDLE is ignored, including the DONE cycle. start held high re-triggers from IDLE on the next cycle.
- An edge detected on the final MEASURE cycle is counted.
- Reset at any time (async): state IDLE, ro_halt=1, busy=0, done=0, count=0, overflow=0, all synchronizer/prev/internal counters 0. The in-flight measurement is discarded with no done pulse.
- Maximum countable ring frequency is below clk/2. Faster rings alias; this is not detected.

## Timing
- All outputs are registered.
- Reset values: ro_halt=1, busy=0, done=0, count=0, overflow=0.
- Cycle numbering: start sampled high in IDLE at edge T.
- Cycle T+1: SETTLE, ro_halt=0, busy=1, count=0, overflow=0.
- Cycles T+1 … T+SETTLE_CYCLES: SETTLE.
- Cycles T+SETTLE_CYCLES+1 … T+SETTLE_CYCLES+N: MEASURE, where N = win_q.
- Cycle T+SETTLE_CYCLES+N+1: DONE, with done=1, ro_halt=1, busy=0, and count final.
- Start→done latency = SETTLE_CYCLES+N+1 cycles. For N=0 it is SETTLE_CYCLES+1 and count=0.
- Next start is accepted at the earliest on the cycle after DONE.

## Test plan
- Reset values: assert rst for 3 cycles mid-run, including with start=1 → ro_halt=1, busy=0, done=0, count=0, overflow=0; no done pulse afterwards.
- Nominal count: defaults, window_cycles=100, bench ro_in square wave of period 10 clk (synchronous to clk, rising edge 1 cycle after T) → done at T+105, count=10, overflow=0, ro_halt low exactly T+1…T+104.
- Idle ring: ro_in held 0, window_cycles=50 → done at T+55, count=0.
- Zero window: window_cycles=0 → done at T+5, count=0, busy high T+1…T+4 only.
- Saturation: COUNT_W=4, ro_in period 4 clk, window_cycles=100 → count=15, overflow=1. The next start clears both at T'+1.
- Busy protection: pulse start again at T+20 and on the DONE cycle with window_cycles changed to 7 → ignored; first result unchanged, exactly one done pulse.
